// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the convolution sequencer: controller
// states, matrix geometry and the {ce, we} RAM enable encodings.
package conv_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_F,
    ST_RUN,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_e;

  localparam int IN_DIM  = 4;
  localparam int F_DIM   = 3;
  localparam int OUT_DIM = 2;
  localparam int N_IN    = 16;
  localparam int N_F     = 9;
  localparam int ACC_W   = 20;

  localparam logic [1:0] EN_IDLE = 2'b00;
  localparam logic [1:0] EN_RD   = 2'b10;
  localparam logic [1:0] EN_WR   = 2'b11;

endpackage

// File: rtl/conv_mac3.sv
// Three-lane 8x8 multiply-accumulate for one row of a 3x3 filter window.
// Holds a 20-bit unsigned accumulator with clear, and narrows the shifted
// accumulator to one byte. Define CONV_SEQ_SAT_EN to saturate at 255;
// otherwise the low byte is kept and large sums wrap.
module conv_mac3
  import conv_seq_pkg::*;
#(
  parameter int OUT_SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       add,
  input  logic [7:0] a0,
  input  logic [7:0] a1,
  input  logic [7:0] a2,
  input  logic [7:0] f0,
  input  logic [7:0] f1,
  input  logic [7:0] f2,
  output logic [7:0] result
);

  logic [15:0]      p0, p1, p2;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] acc_d, acc_q;

  // Products, adder tree and next accumulator value; clear wins over add.
  always_comb begin
    p0    = a0 * f0;
    p1    = a1 * f1;
    p2    = a2 * f2;
    sum   = ACC_W'(p0) + ACC_W'(p1) + ACC_W'(p2);
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (add) begin
      acc_d = acc_q + sum;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

`ifdef CONV_SEQ_SAT_EN
  logic [ACC_W-1:0] shifted;

  // Shift then clamp to the byte range.
  always_comb begin
    shifted = acc_q >> OUT_SHIFT;
    result  = (shifted > ACC_W'(255)) ? 8'hFF : shifted[7:0];
  end
`else
  // Shift then keep the low byte.
  always_comb begin
    result = 8'(acc_q >> OUT_SHIFT);
  end
`endif

endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequencer for the convolution memory subsystem: loads a 4x4 input and a
// 3x3 filter into their RAMs, then runs a serial 3x3 valid convolution and
// writes the four results into the serial-output RAM.
// Optional build macro CONV_SEQ_SAT_EN selects saturating result narrowing.
module conv_seq_ctrl
  import conv_seq_pkg::*;
#(
  parameter int OUT_SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] data_w,
  output logic [3:0] addr_A0,
  output logic [3:0] addr_A1,
  output logic [3:0] addr_A2,
  output logic [3:0] addr_F0,
  output logic [3:0] addr_F1,
  output logic [3:0] addr_F2,
  output logic [1:0] addr_S0,
  output logic [1:0] en_INP,
  output logic [1:0] en_FIL,
  output logic [1:0] en_S,
  input  logic [7:0] rd_A0,
  input  logic [7:0] rd_A1,
  input  logic [7:0] rd_A2,
  input  logic [7:0] rd_F0,
  input  logic [7:0] rd_F1,
  input  logic [7:0] rd_F2
);

  state_e     state_d, state_q;
  logic [3:0] cnt_d, cnt_q;        // accepted bytes in the current load phase
  logic [1:0] i_d, i_q;            // filter row being issued
  logic [1:0] k_d, k_q;            // output index k = 2r + c
  logic       issued_d, issued_q;  // a RUN issue happened last cycle
  logic       busy_d, busy_q;
  logic       in_ready_d, in_ready_q;
  logic       done_d, done_q;

  logic       xfer;
  logic [1:0] row;
  logic [3:0] base_a;
  logic [7:0] result;

  assign xfer     = in_ready_q && in_valid;
  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Next-state, counter and registered-output logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    i_d      = i_q;
    k_d      = k_q;
    issued_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD_A;
          cnt_d   = '0;
        end
      end
      ST_LOAD_A: begin
        if (xfer) begin
          if (cnt_q == 4'(N_IN - 1)) begin
            state_d = ST_LOAD_F;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ST_LOAD_F: begin
        if (xfer) begin
          if (cnt_q == 4'(N_F - 1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            i_d     = '0;
            k_d     = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ST_RUN: begin
        issued_d = 1'b1;
        if (i_q == 2'(F_DIM - 1)) begin
          state_d = ST_DRAIN;
          i_d     = '0;
        end else begin
          i_d = i_q + 2'd1;
        end
      end
      ST_DRAIN: state_d = ST_WRITE;
      ST_WRITE: begin
        if (k_q == 2'(OUT_DIM * OUT_DIM - 1)) begin
          state_d = ST_DONE;
          k_d     = '0;
        end else begin
          state_d = ST_RUN;
          k_d     = k_q + 2'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d     = (state_d != ST_IDLE);
    in_ready_d = (state_d == ST_LOAD_A) || (state_d == ST_LOAD_F);
    done_d     = (state_d == ST_DONE);
  end

  // Controller state, counters and registered status outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      i_q        <= '0;
      k_q        <= '0;
      issued_q   <= 1'b0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      i_q        <= i_d;
      k_q        <= k_d;
      issued_q   <= issued_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
    end
  end

  // Memory bus: load writes, window reads during RUN, result write.
  always_comb begin
    row     = {1'b0, k_q[1]} + i_q;
    base_a  = 4'(row * IN_DIM) + {3'b000, k_q[0]};
    data_w  = '0;
    addr_A0 = '0;
    addr_A1 = '0;
    addr_A2 = '0;
    addr_F0 = '0;
    addr_F1 = '0;
    addr_F2 = '0;
    addr_S0 = '0;
    en_INP  = EN_IDLE;
    en_FIL  = EN_IDLE;
    en_S    = EN_IDLE;
    case (state_q)
      ST_LOAD_A: begin
        if (xfer) begin
          data_w  = in_data;
          addr_A0 = cnt_q;
          en_INP  = EN_WR;
        end
      end
      ST_LOAD_F: begin
        if (xfer) begin
          data_w  = in_data;
          addr_F0 = cnt_q;
          en_FIL  = EN_WR;
        end
      end
      ST_RUN: begin
        addr_A0 = base_a;
        addr_A1 = base_a + 4'd1;
        addr_A2 = base_a + 4'd2;
        addr_F0 = 4'(i_q * F_DIM);
        addr_F1 = 4'(i_q * F_DIM) + 4'd1;
        addr_F2 = 4'(i_q * F_DIM) + 4'd2;
        en_INP  = EN_RD;
        en_FIL  = EN_RD;
      end
      ST_WRITE: begin
        data_w  = result;
        addr_S0 = k_q;
        en_S    = EN_WR;
      end
      default: ;
    endcase
  end

  conv_mac3 #(
    .OUT_SHIFT(OUT_SHIFT)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr   ((state_q == ST_RUN) && (i_q == 2'd0)),
    .add   (issued_q),
    .a0    (rd_A0),
    .a1    (rd_A1),
    .a2    (rd_A2),
    .f0    (rd_F0),
    .f1    (rd_F1),
    .f2    (rd_F2),
    .result(result)
  );

endmodule
